mem_test_initiator: RTL and testbench

- Requester side of the memory controller read/write interface.
- Given a start command, it writes an incrementing data pattern over an address window, then reads the window back and compares each word against the expected value.
- Reports pass/fail, an error count and the first failing address.
- Sits between a test/control register block and the memory controller; it drives valid, rd/wr select, address and write data, and consumes read data.

---
 rtl/mem_test_initiator.sv | 215 +++++++++++++++++++++
 tb/tb_mem_test_initiator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_test_initiator.sv
// rtl/mem_test_initiator.sv - write/read-back memory pattern tester (optional MEMTEST_ERR_INJECT_EN)
module mem_test_initiator #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [DATA_WIDTH-1:0] seed,
`ifdef MEMTEST_ERR_INJECT_EN
  input  logic                  inject_err,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  mem_rd_wr_valid,
  output logic                  mem_rd_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  // Marks the oldest pipeline stage; DRAIN may finish once every younger stage is empty.
  localparam logic [RD_LATENCY-1:0] LAST_MASK = RD_LATENCY'(1) << (RD_LATENCY - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   num_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic                  pass_q;
  logic [ADDR_WIDTH:0]   err_q;
  logic [ADDR_WIDTH-1:0] first_err_q;

  logic [RD_LATENCY-1:0] pipe_vld_q;
  logic [DATA_WIDTH-1:0] pipe_exp_q  [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] pipe_addr_q [RD_LATENCY];

  logic                  accept;
  logic                  idx_last;
  logic                  push;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] pattern;
  logic [DATA_WIDTH-1:0] wr_pattern;
  logic                  cmp_vld;
  logic                  mismatch;

  assign accept   = (state_q == S_IDLE) && start;
  assign idx_last = ({1'b0, idx_q} == (num_q - (ADDR_WIDTH + 1)'(1)));
  assign req_addr = base_q + idx_q;
  assign pattern  = seed_q + DATA_WIDTH'(idx_q);
  assign cmp_vld  = pipe_vld_q[RD_LATENCY-1];
  assign mismatch = (mem_rd_data != pipe_exp_q[RD_LATENCY-1]);

`ifdef MEMTEST_ERR_INJECT_EN
  logic inj_q;

  // Capture the inject request alongside the run parameters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inj_q <= 1'b0;
    end else if (accept) begin
      inj_q <= inject_err;
    end
  end

  // Only the first write is corrupted; the expected value stays clean.
  assign wr_pattern = pattern ^ {{(DATA_WIDTH-1){1'b0}}, (inj_q && (idx_q == '0))};
`else
  assign wr_pattern = pattern;
`endif

  // State and index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic and request outputs, decoded straight from the current state.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    busy            = 1'b0;
    done            = 1'b0;
    mem_rd_wr_valid = 1'b0;
    mem_rd_wr       = 1'b0;
    mem_addr        = '0;
    mem_wr_data     = '0;
    push            = 1'b0;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start) begin
          state_d = (num_words == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        busy            = 1'b1;
        mem_rd_wr_valid = 1'b1;
        mem_rd_wr       = 1'b1;
        mem_addr        = req_addr;
        mem_wr_data     = wr_pattern;
        if (idx_last) begin
          state_d = S_READ;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_READ: begin
        busy            = 1'b1;
        mem_rd_wr_valid = 1'b1;
        mem_addr        = req_addr;
        push            = 1'b1;
        if (idx_last) begin
          state_d = S_DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if ((pipe_vld_q & ~LAST_MASK) == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Latch run parameters when a start is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q <= '0;
      num_q  <= '0;
      seed_q <= '0;
    end else if (accept) begin
      base_q <= base_addr;
      num_q  <= num_words;
      seed_q <= seed;
    end
  end

  // Expected-data pipeline aligning each read with its returning data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        pipe_exp_q[k]  <= '0;
        pipe_addr_q[k] <= '0;
      end
    end else begin
      pipe_vld_q[0]  <= push;
      pipe_exp_q[0]  <= pattern;
      pipe_addr_q[0] <= req_addr;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_vld_q[k]  <= pipe_vld_q[k-1];
        pipe_exp_q[k]  <= pipe_exp_q[k-1];
        pipe_addr_q[k] <= pipe_addr_q[k-1];
      end
    end
  end

  // Result tracking: cleared on a new run, updated whenever returned data mismatches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_q      <= 1'b1;
      err_q       <= '0;
      first_err_q <= '0;
    end else if (accept) begin
      pass_q      <= 1'b1;
      err_q       <= '0;
      first_err_q <= '0;
    end else if (cmp_vld && mismatch) begin
      pass_q <= 1'b0;
      if (err_q != '1) begin
        err_q <= err_q + 1'b1;
      end
      if (err_q == '0) begin
        first_err_q <= pipe_addr_q[RD_LATENCY-1];
      end
    end
  end

  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_mem_test_initiator.sv
// tb/tb_mem_test_initiator.sv - table-driven bench for mem_test_initiator
module tb_mem_test_initiator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [16:0] num_words;
  logic [31:0] seed;
`ifdef MEMTEST_ERR_INJECT_EN
  logic        inject_err;
`endif
  logic        busy;
  logic        done;
  logic        pass;
  logic [16:0] err_count;
  logic [15:0] first_err_addr;
  logic        mem_rd_wr_valid;
  logic        mem_rd_wr;
  logic [15:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  int tests_run;
  int tests_failed;

  int          corrupt_mode;
  logic [15:0] corrupt_addr;
  logic [31:0] mem [0:65535];

  typedef struct {
    logic [15:0] base;
    logic [16:0] n;
    logic [31:0] seed;
    int          corrupt;
    logic [15:0] caddr;
    int          poke_start;
    int          inj;
    logic        exp_pass;
    logic [16:0] exp_err;
    logic [15:0] exp_first;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  mem_test_initiator dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .base_addr       (base_addr),
    .num_words       (num_words),
    .seed            (seed),
`ifdef MEMTEST_ERR_INJECT_EN
    .inject_err      (inject_err),
`endif
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_addr  (first_err_addr),
    .mem_rd_wr_valid (mem_rd_wr_valid),
    .mem_rd_wr       (mem_rd_wr),
    .mem_addr        (mem_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_rd_data     (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal one-cycle-latency memory with optional read corruption.
  always @(posedge clk) begin
    if (mem_rd_wr_valid && mem_rd_wr) mem[mem_addr] <= mem_wr_data;
    if (mem_rd_wr_valid && !mem_rd_wr)
      mem_rd_data <= mem[mem_addr] ^
        (((corrupt_mode == 2) || ((corrupt_mode == 1) && (mem_addr == corrupt_addr))) ? 32'h1 : 32'h0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int          lat;
    int          nreq;
    int          seq_err;
    int          nn;
    logic [15:0] ea;
    logic [31:0] ed;
    logic        ew;
    nn           = int'(v.n);
    corrupt_mode = v.corrupt;
    corrupt_addr = v.caddr;
    base_addr    = v.base;
    num_words    = v.n;
    seed         = v.seed;
`ifdef MEMTEST_ERR_INJECT_EN
    inject_err   = (v.inj != 0);
`endif
    start        = 1'b1;
    tick();
    start        = 1'b0;
`ifdef MEMTEST_ERR_INJECT_EN
    inject_err   = 1'b0;
`endif
    lat     = 0;
    nreq    = 0;
    seq_err = 0;
    for (int c = 1; c <= 300; c++) begin
      if (v.poke_start != 0 && c == 2) begin
        start     = 1'b1;
        num_words = 17'd1;
      end
      if (v.poke_start != 0 && c == 3) begin
        start     = 1'b0;
        num_words = v.n;
      end
      if (mem_rd_wr_valid) begin
        if (nreq < nn) begin
          ea = v.base + 16'(nreq);
          ed = v.seed + 32'(nreq);
          if (nreq == 0 && v.inj != 0) ed = ed ^ 32'h1;
          ew = 1'b1;
        end else begin
          ea = v.base + 16'(nreq - nn);
          ed = 32'h0;
          ew = 1'b0;
        end
        if (mem_addr !== ea || mem_wr_data !== ed || mem_rd_wr !== ew) seq_err++;
        nreq++;
      end
      if (done) begin
        lat = c;
        break;
      end
      tick();
    end
    chk($sformatf("v%0d_latency", id), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("v%0d_req_count", id), 64'(nreq), 64'(2 * nn));
    chk($sformatf("v%0d_req_seq_errs", id), 64'(seq_err), 64'd0);
    chk($sformatf("v%0d_pass", id), 64'(pass), 64'(v.exp_pass));
    chk($sformatf("v%0d_err_count", id), 64'(err_count), 64'(v.exp_err));
    chk($sformatf("v%0d_first_err", id), 64'(first_err_addr), 64'(v.exp_first));
    tick();
    chk($sformatf("v%0d_after_idle", id), {62'd0, busy, done}, 64'd0);
    chk($sformatf("v%0d_hold", id), {46'd0, pass, err_count}, {46'd0, v.exp_pass, v.exp_err});
  endtask

  initial begin
    int   dpulses;
    int   idle_bad;
    vec_t v;

    tests_run    = 0;
    tests_failed = 0;
    corrupt_mode = 0;
    corrupt_addr = 16'h0;
    mem_rd_data  = 32'h0;
    rst_n        = 1'b0;
    start        = 1'b0;
    base_addr    = 16'h0;
    num_words    = 17'd0;
    seed         = 32'h0;
`ifdef MEMTEST_ERR_INJECT_EN
    inject_err   = 1'b0;
`endif

    //           base      n       seed          cor caddr     pk inj pass err    first     lat
    vecs[0] = '{16'h0010, 17'd4, 32'hA5A50000, 0, 16'h0000, 0, 0, 1'b1, 17'd0, 16'h0000, 10};
    vecs[1] = '{16'hFFFE, 17'd4, 32'h12345678, 0, 16'h0000, 0, 0, 1'b1, 17'd0, 16'h0000, 10};
    vecs[2] = '{16'h0010, 17'd4, 32'h00000000, 1, 16'h0012, 0, 0, 1'b0, 17'd1, 16'h0012, 10};
    vecs[3] = '{16'h0100, 17'd5, 32'h00000007, 2, 16'h0000, 0, 0, 1'b0, 17'd5, 16'h0100, 12};
    vecs[4] = '{16'h0000, 17'd0, 32'h00000000, 0, 16'h0000, 0, 0, 1'b1, 17'd0, 16'h0000, 1};
    vecs[5] = '{16'h0000, 17'd3, 32'hFFFFFFFF, 0, 16'h0000, 0, 0, 1'b1, 17'd0, 16'h0000, 8};
    vecs[6] = '{16'h0020, 17'd6, 32'h00000010, 0, 16'h0000, 1, 0, 1'b1, 17'd0, 16'h0000, 14};
    vecs[7] = '{16'h0000, 17'd1, 32'h00000000, 2, 16'h0000, 0, 0, 1'b0, 17'd1, 16'h0000, 4};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd1);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_first_err", 64'(first_err_addr), 64'd0);
    chk("rst_req", {14'd0, mem_rd_wr_valid, mem_rd_wr, mem_addr, mem_wr_data}, 64'd0);
    idle_bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_rd_wr_valid || busy || done || !pass) idle_bad++;
      tick();
    end
    chk("idle_20_cycles", 64'(idle_bad), 64'd0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset during the READ phase of an 8-word run.
    corrupt_mode = 0;
    base_addr    = 16'h0040;
    num_words    = 17'd8;
    seed         = 32'h0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("midrst_in_read", {62'd0, mem_rd_wr_valid, mem_rd_wr}, 64'd2);
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", 64'(mem_rd_wr_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst_n   = 1'b1;
    dpulses = 0;
    if (done) dpulses++;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done || busy) dpulses++;
    end
    chk("midrst_no_done", 64'(dpulses), 64'd0);
    v = '{16'h0200, 17'd2, 32'hCAFE0000, 0, 16'h0000, 0, 0, 1'b1, 17'd0, 16'h0000, 6};
    run_vec(8, v);

`ifdef MEMTEST_ERR_INJECT_EN
    v = '{16'h0300, 17'd4, 32'h00000100, 0, 16'h0000, 0, 1, 1'b0, 17'd1, 16'h0300, 10};
    run_vec(9, v);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
